uart_xcvr: RTL

Parametrised full-duplex UART transceiver. It replaces the fixed 8N1, fixed-baud echo block with configurable data width, stop bits and runtime baud divisor. RX and TX expose valid/ready handshakes, and an echo mode routes received bytes straight back to TX. It sits between the board UART pins and the on-chip command/debug logic.

---
 rtl/uart_xcvr.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with valid/ready on both sides and RX->TX echo mode.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_xcvr #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DIV_BITS-1:0]  i_div,
  input  logic                 i_echo,
  input  logic                 i_rxd,
  output logic                 o_txd,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_overrun,
  output logic                 o_rx_busy
`ifdef UART_PARITY_EN
  ,
  input  logic                 i_parity_odd,
  output logic                 o_rx_parity_err
`endif
);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } st_t;
  localparam logic [DIV_BITS:0] ONE = (DIV_BITS+1)'(1);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  st_t tx_st, rx_st;
  logic echo_q;
  logic [DIV_BITS-1:0] div_eff, tx_div, rx_div;
  logic [DIV_BITS:0] tx_cnt, tx_bit, tx_stop, rx_cnt, rx_bit;
  logic [3:0] tx_idx, rx_idx;
  logic [DATA_BITS-1:0] tx_sh, tx_din, rx_sh, rx_hold;
  logic tx_rdy, tx_go, rx_acc, rx_done, rx_vld, rx_ferr, rx_ovr, rxs, rx_prev;
  logic [1:0] rx_sync;
`ifdef UART_PARITY_EN
  logic tx_par, rx_odd, rx_pbit, rx_perr;
  assign o_rx_parity_err = rx_perr & o_rx_valid;
`endif
  assign div_eff = (i_div < DIV_BITS'(2)) ? DIV_BITS'(2) : i_div;
  assign tx_bit = {1'b0, tx_div} - ONE;
  assign tx_stop = ({1'b0, tx_div} << (STOP_BITS - 1)) - ONE;
  assign rx_bit = {1'b0, rx_div} - ONE;
  assign rxs = rx_sync[1];
  // In echo mode the holding register is the TX source and TX acceptance is the RX accept
  assign tx_rdy = (tx_st == IDLE) & ~i_reset;
  assign tx_din = echo_q ? rx_hold : i_tx_data;
  assign tx_go = tx_rdy & (echo_q ? rx_vld : i_tx_valid);
  assign rx_acc = rx_vld & (echo_q ? tx_rdy : i_rx_ready);
  assign rx_done = (rx_st == STOP) && (rx_cnt == '0);
  assign o_tx_ready = tx_rdy & ~echo_q;
  assign o_rx_valid = rx_vld & ~echo_q;
  assign o_rx_data = rx_hold;
  assign o_rx_frame_err = rx_ferr & o_rx_valid;
  assign o_rx_overrun = rx_ovr;
  assign o_rx_busy = rx_st != IDLE;

  always_ff @(posedge clk)
    if (i_reset) echo_q <= 1'b0;
    else if (tx_st == IDLE && rx_st == IDLE) echo_q <= i_echo;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      tx_st <= IDLE;
      o_txd <= 1'b1;
      o_tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_div <= '0;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else if (tx_st == IDLE) begin
      if (tx_go) begin
        tx_st <= START;
        o_txd <= 1'b0;
        o_tx_busy <= 1'b1;
        tx_div <= div_eff;
        tx_cnt <= {1'b0, div_eff} - ONE;
        tx_sh <= tx_din;
`ifdef UART_PARITY_EN
        tx_par <= ^tx_din ^ i_parity_odd;
`endif
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - ONE;
    end else begin
      case (tx_st)
        START: begin
          tx_st <= DATA;
          o_txd <= tx_sh[0];
          tx_cnt <= tx_bit;
          tx_idx <= '0;
        end
        DATA: begin
          tx_cnt <= tx_bit;
          tx_idx <= tx_idx + 4'd1;
          tx_sh <= tx_sh >> 1;
          o_txd <= tx_sh[1];
          if (tx_idx == LAST) begin
`ifdef UART_PARITY_EN
            tx_st <= PARITY;
            o_txd <= tx_par;
`else
            tx_st <= STOP;
            o_txd <= 1'b1;
            tx_cnt <= tx_stop;
`endif
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          tx_st <= STOP;
          o_txd <= 1'b1;
          tx_cnt <= tx_stop;
        end
`endif
        default: begin
          tx_st <= IDLE;
          o_txd <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_st <= IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_div <= '0;
`ifdef UART_PARITY_EN
      rx_odd <= 1'b0;
      rx_pbit <= 1'b0;
`endif
    end else begin
      rx_sync <= {rx_sync[0], i_rxd};
      rx_prev <= rxs;
      if (rx_st == IDLE) begin
        if (rx_prev && !rxs) begin
          rx_st <= START;
          rx_div <= div_eff;
          rx_cnt <= {1'b0, div_eff >> 1} - ONE;
`ifdef UART_PARITY_EN
          rx_odd <= i_parity_odd;
`endif
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - ONE;
      end else begin
        case (rx_st)
          START: begin
            rx_st <= rxs ? IDLE : DATA;
            rx_cnt <= rx_bit;
            rx_idx <= '0;
          end
          DATA: begin
            rx_sh <= {rxs, rx_sh[DATA_BITS-1:1]};
            rx_cnt <= rx_bit;
            rx_idx <= rx_idx + 4'd1;
`ifdef UART_PARITY_EN
            if (rx_idx == LAST) rx_st <= PARITY;
          end
          PARITY: begin
            rx_pbit <= rxs;
            rx_cnt <= rx_bit;
            rx_st <= STOP;
`else
            if (rx_idx == LAST) rx_st <= STOP;
`endif
          end
          default: rx_st <= IDLE;
        endcase
      end
    end
  end

  // A byte arriving while the old one is still unclaimed is dropped and flagged
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_vld <= 1'b0;
      rx_hold <= '0;
      rx_ferr <= 1'b0;
      rx_ovr <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr <= 1'b0;
`endif
    end else begin
      if (rx_done && (!rx_vld || rx_acc)) begin
        rx_vld <= 1'b1;
        rx_hold <= rx_sh;
        rx_ferr <= ~rxs;
`ifdef UART_PARITY_EN
        rx_perr <= rx_pbit ^ (^rx_sh) ^ rx_odd;
`endif
      end else if (rx_acc) begin
        rx_vld <= 1'b0;
      end
      rx_ovr <= (rx_done & rx_vld & ~rx_acc) | (rx_ovr & ~rx_acc);
    end
  end
endmodule
